// File: rtl/dsram_confreg_resp_pkg.sv
// -----------------------------------------------------------------------------
// dsram_confreg_resp_pkg
//   Shared definitions for the data-side SRAM/config-register responder:
//   MMIO window selector, register offsets inside the window, the decoded
//   register enumeration and a byte-lane merge helper used by every
//   byte-writable register.
// -----------------------------------------------------------------------------
package dsram_confreg_resp_pkg;

    // addr[31:16] value that selects the MMIO window.
    localparam logic [15:0] MMIO_HI         = 16'hBFAF;

    // Register offsets (addr[15:0]) inside the MMIO window.
    localparam logic [15:0] LED_ADDR        = 16'hF000;
    localparam logic [15:0] NUM_ADDR        = 16'hF010;
    localparam logic [15:0] SWITCH_ADDR     = 16'hF020;
    localparam logic [15:0] TIMER_ADDR      = 16'hE000;
    localparam logic [15:0] TIMER_CMP_ADDR  = 16'hE004;
    localparam logic [15:0] INT_STATUS_ADDR = 16'hE008;

    typedef enum logic [2:0] {
        REG_NONE,
        REG_LED,
        REG_NUM,
        REG_SWITCH,
        REG_TIMER,
        REG_TIMER_CMP,
        REG_INT_STATUS
    } mmio_reg_e;

    // Map a window offset onto the register it addresses; unmapped offsets
    // decode to REG_NONE (reads 0, writes dropped).
    function automatic mmio_reg_e decode_offset(input logic [15:0] offset);
        mmio_reg_e sel;
        case (offset)
            LED_ADDR:        sel = REG_LED;
            NUM_ADDR:        sel = REG_NUM;
            SWITCH_ADDR:     sel = REG_SWITCH;
            TIMER_ADDR:      sel = REG_TIMER;
            TIMER_CMP_ADDR:  sel = REG_TIMER_CMP;
            INT_STATUS_ADDR: sel = REG_INT_STATUS;
            default:         sel = REG_NONE;
        endcase
        return sel;
    endfunction

    // Replace the byte lanes of old_word whose enable bit is set.
    function automatic logic [31:0] byte_merge(input logic [31:0] old_word,
                                               input logic [31:0] new_word,
                                               input logic [3:0]  be);
        logic [31:0] merged;
        merged = old_word;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) merged[8*i +: 8] = new_word[8*i +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/dsram_confreg_resp_bw_sram.sv
// -----------------------------------------------------------------------------
// dsram_confreg_resp_bw_sram
//   bw_sram: single-port 2^AW x 32 RAM with per-byte write enables and a
//   registered read port. A read (en=1, wen=0) presents the addressed word
//   on rdata after the next clock edge; writes leave rdata untouched.
//
//   Ports:
//     clk    in   clock
//     en     in   access enable
//     wen    in   byte write enables, 0 = read
//     addr   in   word address
//     wdata  in   write data, byte lanes aligned to wen
//     rdata  out  registered read data
// -----------------------------------------------------------------------------
module dsram_confreg_resp_bw_sram #(
    parameter int AW = 14
) (
    input  logic          clk,
    input  logic          en,
    input  logic [3:0]    wen,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [0:(1<<AW)-1];

    // NOTE: the storage array and its read register carry no reset so the
    // array maps onto block RAM; contents are undefined until written.
    always_ff @(posedge clk) begin
        if (en) begin
            if (wen != 4'b0000) begin
                for (int i = 0; i < 4; i++) begin
                    if (wen[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/dsram_confreg_resp.sv
// -----------------------------------------------------------------------------
// dsram_confreg_resp
//   Slave end of the core's data SRAM-like interface. Every access is decoded
//   either to the word-addressed backing RAM or to the MMIO configuration
//   window (LED, number display, switches, timer, timer compare, interrupt
//   status). Read data appears one cycle after the request, which is when
//   the core's MEM stage samples it.
//
//   Ports:
//     clk              in   clock
//     rst              in   synchronous active-high reset
//     data_sram_en     in   access request this cycle
//     data_sram_wen    in   byte write enables, 0 = read
//     data_sram_addr   in   byte address
//     data_sram_wdata  in   write data, byte lanes aligned to wen
//     data_sram_rdata  out  read data, valid the cycle after a read
//     switch_in        in   board switches
//     led              out  LED register
//     num_data         out  seven-segment number register
//     timer_irq        out  level interrupt, mirrors INT_STATUS[0]
// -----------------------------------------------------------------------------
module dsram_confreg_resp
    import dsram_confreg_resp_pkg::*;
#(
    parameter int          RAM_AW     = 14,
    parameter logic [15:0] MMIO_HI_SEL = MMIO_HI
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        data_sram_en,
    input  logic [3:0]  data_sram_wen,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic [31:0] data_sram_rdata,
    input  logic [7:0]  switch_in,
    output logic [15:0] led,
    output logic [31:0] num_data,
    output logic        timer_irq
);

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    logic      mmio_sel;
    mmio_reg_e reg_sel;
    logic      rd_req;
    logic      wr_req;
    logic      mmio_wr;

    assign mmio_sel = (data_sram_addr[31:16] == MMIO_HI_SEL);
    assign reg_sel  = decode_offset(data_sram_addr[15:0]);
    assign rd_req   = data_sram_en && (data_sram_wen == 4'b0000);
    assign wr_req   = data_sram_en && (data_sram_wen != 4'b0000);
    assign mmio_wr  = wr_req && mmio_sel;

    logic wr_led;
    logic wr_num;
    logic wr_timer;
    logic wr_timer_cmp;
    logic int_clear;

    assign wr_led       = mmio_wr && (reg_sel == REG_LED);
    assign wr_num       = mmio_wr && (reg_sel == REG_NUM);
    assign wr_timer     = mmio_wr && (reg_sel == REG_TIMER);
    assign wr_timer_cmp = mmio_wr && (reg_sel == REG_TIMER_CMP);
    // Write-1-to-clear only through byte lane 0, bit 0.
    assign int_clear    = mmio_wr && (reg_sel == REG_INT_STATUS)
                          && data_sram_wen[0] && data_sram_wdata[0];

    // ------------------------------------------------------------------
    // Backing RAM. Higher address bits are simply dropped, so the RAM
    // aliases across the non-MMIO space. Reset suppresses the access.
    // ------------------------------------------------------------------
    logic        ram_en;
    logic [31:0] ram_rdata;

    assign ram_en = data_sram_en && !mmio_sel && !rst;

    dsram_confreg_resp_bw_sram #(
        .AW (RAM_AW)
    ) u_bw_sram (
        .clk   (clk),
        .en    (ram_en),
        .wen   (data_sram_wen),
        .addr  (data_sram_addr[RAM_AW+1:2]),
        .wdata (data_sram_wdata),
        .rdata (ram_rdata)
    );

    // ------------------------------------------------------------------
    // MMIO registers
    // ------------------------------------------------------------------
    logic [15:0] led_q;
    logic [31:0] num_q;
    logic [31:0] timer_q;
    logic [31:0] timer_cmp_q;
    logic        int_status_q;
    logic [15:0] led_next;

    // LED is only 16 bits wide; lanes 2 and 3 have nothing to land in.
    // NOTE: combinational blocks assign a default first so no path leaves
    // the signal unassigned, which would otherwise infer a latch.
    always_comb begin
        led_next = led_q;
        for (int i = 0; i < 2; i++) begin
            if (data_sram_wen[i]) led_next[8*i +: 8] = data_sram_wdata[8*i +: 8];
        end
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples pre-edge values; the timer match below relies on that.
    always_ff @(posedge clk) begin
        if (rst) begin
            led_q        <= 16'h0000;
            num_q        <= 32'h0000_0000;
            timer_q      <= 32'h0000_0000;
            timer_cmp_q  <= 32'h0000_0000;
            int_status_q <= 1'b0;
        end else begin
            if (wr_led)       led_q       <= led_next;
            if (wr_num)       num_q       <= byte_merge(num_q, data_sram_wdata, data_sram_wen);
            if (wr_timer_cmp) timer_cmp_q <= byte_merge(timer_cmp_q, data_sram_wdata, data_sram_wen);

            // A software write replaces the increment for that cycle.
            if (wr_timer) timer_q <= byte_merge(timer_q, data_sram_wdata, data_sram_wen);
            else          timer_q <= timer_q + 32'd1;

            // Match is checked on pre-edge values and beats a same-cycle clear.
            if (timer_q == timer_cmp_q) int_status_q <= 1'b1;
            else if (int_clear)         int_status_q <= 1'b0;
        end
    end

    assign led       = led_q;
    assign num_data  = num_q;
    assign timer_irq = int_status_q;

    // ------------------------------------------------------------------
    // Read path: MMIO data is captured alongside the RAM's own read
    // register, and a registered copy of mmio_sel picks between them.
    // Reset points the mux at the cleared MMIO capture so rdata reads 0.
    // ------------------------------------------------------------------
    logic [31:0] mmio_rdata_next;
    logic [31:0] mmio_rdata_q;
    logic        rd_mmio_q;

    always_comb begin
        mmio_rdata_next = 32'h0000_0000;
        case (reg_sel)
            REG_LED:        mmio_rdata_next = {16'h0000, led_q};
            REG_NUM:        mmio_rdata_next = num_q;
            REG_SWITCH:     mmio_rdata_next = {24'h00_0000, switch_in};
            REG_TIMER:      mmio_rdata_next = timer_q;
            REG_TIMER_CMP:  mmio_rdata_next = timer_cmp_q;
            REG_INT_STATUS: mmio_rdata_next = {31'h0000_0000, int_status_q};
            default:        mmio_rdata_next = 32'h0000_0000;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_mmio_q    <= 1'b1;
            mmio_rdata_q <= 32'h0000_0000;
        end else if (rd_req) begin
            rd_mmio_q <= mmio_sel;
            if (mmio_sel) mmio_rdata_q <= mmio_rdata_next;
        end
    end

    assign data_sram_rdata = rd_mmio_q ? mmio_rdata_q : ram_rdata;

endmodule

// File: tb/tb_dsram_confreg_resp.sv
// -----------------------------------------------------------------------------
// tb_dsram_confreg_resp
//   Self-checking bench for dsram_confreg_resp. Reads push their expected
//   word onto a scoreboard queue; it is popped and compared once the read
//   data is due one edge later. Inputs change and outputs are sampled 1 ns
//   after each rising edge.
// -----------------------------------------------------------------------------
module tb_dsram_confreg_resp;

    localparam int          RAM_AW = 14;
    localparam logic [31:0] MMIO   = 32'hBFAF_0000;

    logic        clk;
    logic        rst;
    logic        data_sram_en;
    logic [3:0]  data_sram_wen;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic [31:0] data_sram_rdata;
    logic [7:0]  switch_in;
    logic [15:0] led;
    logic [31:0] num_data;
    logic        timer_irq;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_q [$];
    string       name_q [$];

    dsram_confreg_resp #(
        .RAM_AW      (RAM_AW),
        .MMIO_HI_SEL (16'hBFAF)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .data_sram_en    (data_sram_en),
        .data_sram_wen   (data_sram_wen),
        .data_sram_addr  (data_sram_addr),
        .data_sram_wdata (data_sram_wdata),
        .data_sram_rdata (data_sram_rdata),
        .switch_in       (switch_in),
        .led             (led),
        .num_data        (num_data),
        .timer_irq       (timer_irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // One clock edge with the given request; any read due at this edge is
    // popped from the scoreboard and compared.
    task automatic step(input logic en, input logic [3:0] wen,
                        input logic [31:0] addr, input logic [31:0] wdata);
        data_sram_en    = en;
        data_sram_wen   = wen;
        data_sram_addr  = addr;
        data_sram_wdata = wdata;
        @(posedge clk);
        #1;
        data_sram_en = 1'b0;
        while (exp_q.size() > 0) begin
            logic [31:0] e;
            string       n;
            e = exp_q.pop_front();
            n = name_q.pop_front();
            checks++;
            if (data_sram_rdata !== e) begin
                errors++;
                $display("FAIL %s: rdata got %h want %h", n, data_sram_rdata, e);
            end
        end
    endtask

    task automatic wr(input logic [31:0] addr, input logic [3:0] wen, input logic [31:0] wdata);
        step(1'b1, wen, addr, wdata);
    endtask

    task automatic rd(input logic [31:0] addr, input logic [31:0] exp, input string name);
        exp_q.push_back(exp);
        name_q.push_back(name);
        step(1'b1, 4'b0000, addr, 32'h0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 4'b0000, 32'h0, 32'h0);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        idle(2);
        checks++;
        if (data_sram_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h want 0", data_sram_rdata); end
        checks++;
        if (led !== 16'h0) begin errors++; $display("FAIL reset_led: got %h want 0", led); end
        checks++;
        if (num_data !== 32'h0) begin errors++; $display("FAIL reset_num: got %h want 0", num_data); end
        checks++;
        if (timer_irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b want 0", timer_irq); end
        rst = 1'b0;
    endtask

    task automatic test_ram_bytes;
        wr(32'h0000_0100, 4'hF, 32'h1122_3344);
        wr(32'h0000_0100, 4'b0010, 32'h0000_AA00);
        rd(32'h0000_0100, 32'h1122_AA44, "ram_byte_write");
        // A write must leave rdata holding the last read value.
        wr(32'h0000_0104, 4'hF, 32'h5555_5555);
        checks++;
        if (data_sram_rdata !== 32'h1122_AA44) begin
            errors++;
            $display("FAIL rdata_hold_on_write: got %h want 1122aa44", data_sram_rdata);
        end
        wr(32'h0000_0104, 4'b1001, 32'hAB00_00CD);
        rd(32'h0000_0104, 32'hAB55_55CD, "ram_lanes_0_3");
    endtask

    task automatic test_alias;
        logic [31:0] alias_addr;
        alias_addr = 32'h0000_0010 + (32'd4 << RAM_AW);
        wr(32'h0000_0010, 4'hF, 32'hDEAD_BEEF);
        rd(alias_addr, 32'hDEAD_BEEF, "ram_alias");
    endtask

    task automatic test_back_to_back;
        wr(32'h0000_0300, 4'hF, 32'h0BAD_C0DE);
        rd(32'h0000_0300, 32'h0BAD_C0DE, "write_then_read");
        rd(32'h0000_0100, 32'h1122_AA44, "read_after_read");
    endtask

    task automatic test_mmio;
        wr(MMIO | 32'hF000, 4'hF, 32'hFFFF_1234);
        checks++;
        if (led !== 16'h1234) begin errors++; $display("FAIL led_port: got %h want 1234", led); end
        rd(MMIO | 32'hF000, 32'h0000_1234, "led_readback");
        wr(MMIO | 32'hF010, 4'hF, 32'h1234_5678);
        wr(MMIO | 32'hF010, 4'b0001, 32'h0000_00FF);
        checks++;
        if (num_data !== 32'h1234_56FF) begin errors++; $display("FAIL num_port: got %h want 123456ff", num_data); end
        rd(MMIO | 32'hF010, 32'h1234_56FF, "num_readback");
        switch_in = 8'h5A;
        rd(MMIO | 32'hF020, 32'h0000_005A, "switch_read");
        wr(MMIO | 32'hF020, 4'hF, 32'hFFFF_FFFF);
        rd(MMIO | 32'hF020, 32'h0000_005A, "switch_write_ignored");
    endtask

    task automatic test_timer_irq;
        wr(MMIO | 32'hE004, 4'hF, 32'd20);
        wr(MMIO | 32'hE000, 4'hF, 32'd0);   // edge E: TIMER=0
        wr(MMIO | 32'hE008, 4'h1, 32'd1);   // E+1: clear any earlier set
        checks++;
        if (timer_irq !== 1'b0) begin errors++; $display("FAIL irq_cleared: got %b want 0", timer_irq); end
        idle(19);                           // through E+20
        checks++;
        if (timer_irq !== 1'b0) begin errors++; $display("FAIL irq_early: got %b want 0", timer_irq); end
        idle(1);                            // E+21: pre-edge TIMER==20
        checks++;
        if (timer_irq !== 1'b1) begin errors++; $display("FAIL irq_rise: got %b want 1", timer_irq); end
        rd(MMIO | 32'hE008, 32'h0000_0001, "int_status_read");
        rd(MMIO | 32'hE004, 32'd20, "timer_cmp_read");
        wr(MMIO | 32'hE000, 4'hF, 32'd17);  // edge F
        idle(3);                            // pre-edge TIMER 17,18,19
        wr(MMIO | 32'hE008, 4'h1, 32'd1);   // pre-edge TIMER==20: set wins
        checks++;
        if (timer_irq !== 1'b1) begin errors++; $display("FAIL w1c_on_match: got %b want 1", timer_irq); end
        wr(MMIO | 32'hE008, 4'h1, 32'd1);   // no match: clear
        checks++;
        if (timer_irq !== 1'b0) begin errors++; $display("FAIL w1c_clear: got %b want 0", timer_irq); end
    endtask

    task automatic test_timer_wrap;
        wr(MMIO | 32'hE000, 4'hF, 32'hFFFF_FFFE);
        rd(MMIO | 32'hE000, 32'hFFFF_FFFE, "timer_wr_value");
        rd(MMIO | 32'hE000, 32'hFFFF_FFFF, "timer_inc");
        rd(MMIO | 32'hE000, 32'h0000_0000, "timer_wrap");
        rd(MMIO | 32'hE000, 32'h0000_0001, "timer_after_wrap");
    endtask

    task automatic test_reset_mid;
        wr(32'h0000_0200, 4'hF, 32'hCAFE_F00D);
        wr(MMIO | 32'hE004, 4'hF, 32'd5);
        wr(MMIO | 32'hE000, 4'hF, 32'd3);
        idle(3);                            // pre-edge TIMER 3,4,5
        checks++;
        if (timer_irq !== 1'b1) begin errors++; $display("FAIL irq_before_reset: got %b want 1", timer_irq); end
        wr(MMIO | 32'hF000, 4'b0011, 32'h0000_00FF);
        rd(MMIO | 32'hF000, 32'h0000_00FF, "led_before_reset");
        rst = 1'b1;
        step(1'b1, 4'b0000, MMIO | 32'hF000, 32'h0);
        rst = 1'b0;
        checks++;
        if (data_sram_rdata !== 32'h0) begin errors++; $display("FAIL mid_reset_rdata: got %h want 0", data_sram_rdata); end
        checks++;
        if (led !== 16'h0) begin errors++; $display("FAIL mid_reset_led: got %h want 0", led); end
        checks++;
        if (timer_irq !== 1'b0) begin errors++; $display("FAIL mid_reset_irq: got %b want 0", timer_irq); end
        checks++;
        if (num_data !== 32'h0) begin errors++; $display("FAIL mid_reset_num: got %h want 0", num_data); end
        rd(32'h0000_0200, 32'hCAFE_F00D, "ram_survives_reset");
        rd(MMIO | 32'h0004, 32'h0000_0000, "unmapped_read");
    endtask

    initial begin
        rst             = 1'b1;
        data_sram_en    = 1'b0;
        data_sram_wen   = 4'b0000;
        data_sram_addr  = 32'h0;
        data_sram_wdata = 32'h0;
        switch_in       = 8'h00;
        test_reset;
        test_ram_bytes;
        test_alias;
        test_back_to_back;
        test_mmio;
        test_timer_irq;
        test_timer_wrap;
        test_reset_mid;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
